// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//
// Shares one synchronous single-port data RAM between two requesters: the
// CPU (c_*) and a debug/loader port (d_*). One access is served at a time
// through a four-state sequence IDLE -> ISSUE -> WAIT -> DONE, so a request
// seen in IDLE is acknowledged three cycles later and the arbiter completes
// at most one access every four cycles. When both requesters ask in the
// same IDLE cycle, the one that did not win last time is served
// (round-robin), so neither can starve the other.
//
// Ports
//   clk        single clock, rising edge
//   i_rst_n    asynchronous active-low reset
//   c_req      CPU request, held high until c_ack
//   c_we       CPU write enable (1 = write, 0 = read)
//   c_addr     CPU address            [AW-1:0]
//   c_wdata    CPU write data         [DW-1:0]
//   c_ack      CPU access complete, one-cycle pulse
//   d_req/d_we/d_addr/d_wdata/d_ack   debug requester, same meaning as c_*
//   rdata      read data for the acked requester, valid with c_ack/d_ack
//   m_en       RAM strobe (high only in ISSUE)
//   m_we       RAM write enable (high only in ISSUE for writes)
//   m_addr     RAM address, holds the latched address
//   m_wdata    RAM write data, holds the latched data
//   m_rdata    RAM read data, valid the cycle after m_en
//   busy       high in every state except IDLE
//   owner      last granted requester (0 = CPU, 1 = debug)
// ---------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int AW = 5,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          i_rst_n,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] rdata,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic          busy,
  output logic          owner
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e        state_q, state_d;

  // ptr_q is both the round-robin pointer and the latched winner of the
  // access in flight, because it only moves on the IDLE->ISSUE edge.
  logic          ptr_q, ptr_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic          any_req;
  logic          winner;

  assign any_req = c_req | d_req;

  // A lone request wins outright; on a tie the requester that is not the
  // last-granted one wins. The pointer resets to debug so the CPU takes the
  // first tie after reset.
  always_comb begin
    if (c_req && d_req) begin
      winner = ~ptr_q;
    end else begin
      winner = d_req;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Requests are only looked at in IDLE; the other states
  // advance unconditionally, which fixes the three-cycle latency.
  always_comb begin
    state_d = IDLE;
    unique case (state_q)
      IDLE:    state_d = any_req ? ISSUE : IDLE;
      ISSUE:   state_d = WAIT;
      WAIT:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture and read-data capture. Everything about the access is
  // frozen on the grant edge so later requester activity cannot disturb it.
  // The RAM returns data during WAIT, so reads are captured on WAIT->DONE.
  always_comb begin
    ptr_d   = ptr_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    if (state_q == IDLE && any_req) begin
      ptr_d   = winner;
      we_d    = winner ? d_we    : c_we;
      addr_d  = winner ? d_addr  : c_addr;
      wdata_d = winner ? d_wdata : c_wdata;
    end
    if (state_q == WAIT && !we_q) begin
      rdata_d = m_rdata;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q   <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Output decode. All outputs come straight from registers, so asserting
  // reset clears them immediately without waiting for a clock edge.
  always_comb begin
    m_en    = 1'b0;
    m_we    = 1'b0;
    busy    = 1'b0;
    c_ack   = 1'b0;
    d_ack   = 1'b0;
    m_addr  = addr_q;
    m_wdata = wdata_q;
    rdata   = rdata_q;
    owner   = ptr_q;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
      end
      ISSUE: begin
        busy = 1'b1;
        m_en = 1'b1;
        m_we = we_q;
      end
      WAIT: begin
        busy = 1'b1;
      end
      DONE: begin
        busy  = 1'b1;
        c_ack = ~ptr_q;
        d_ack = ptr_q;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Drives dmem_arbiter against a small synchronous RAM and compares every
// cycle with a transaction-level model: each grant is recorded with its
// cycle number, and the expected strobes/acks are placed at grant+1 and
// grant+3. A reference memory array gives the expected read data.
// Directed sequences with literal values come first, then random traffic.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

  localparam int AW = 5;
  localparam int DW = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          i_rst_n;
  logic          cReq, cWe, dReq, dWe;
  logic [AW-1:0] cAddr, dAddr;
  logic [DW-1:0] cWdata, dWdata;
  logic          c_ack, d_ack;
  logic [DW-1:0] rdata;
  logic          m_en, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] mRdata;
  logic          busy, owner;

  // RAM environment with a back-door load port used only while in reset.
  logic          memLoadEn;
  logic [AW-1:0] memLoadAddr;
  logic [DW-1:0] memLoadData;
  logic [DW-1:0] ram [DEPTH];

  // Model state.
  logic [DW-1:0] refMem [DEPTH];
  int            t;
  int            g;
  logic          gw;
  logic          gwe;
  logic [AW-1:0] expAddr;
  logic [DW-1:0] expWdata;
  logic          ownerExp;
  logic [DW-1:0] rdExp;

  int            nCompared;
  int            nMismatched;

  dmem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .c_req   (cReq),
    .c_we    (cWe),
    .c_addr  (cAddr),
    .c_wdata (cWdata),
    .c_ack   (c_ack),
    .d_req   (dReq),
    .d_we    (dWe),
    .d_addr  (dAddr),
    .d_wdata (dWdata),
    .d_ack   (d_ack),
    .rdata   (rdata),
    .m_en    (m_en),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_rdata (mRdata),
    .busy    (busy),
    .owner   (owner)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous single-port RAM: read data appears the cycle after m_en.
  always @(posedge clk) begin
    if (memLoadEn) begin
      ram[memLoadAddr] <= memLoadData;
    end else if (m_en) begin
      if (m_we) begin
        ram[m_addr] <= m_wdata;
      end
      mRdata <= ram[m_addr];
    end
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [DW-1:0] initWord(input int a);
    if (a == 3) return 8'h5A;
    if (a == 2) return 8'hC3;
    return DW'(a * 37 + 11);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, t);
    end
  endtask

  // Expected outputs for cycle t derived from the last grant cycle g.
  task automatic compareAll();
    logic expIssue, expDone, expBusy;
    expIssue = (g >= 0) && (t == g + 1);
    expDone  = (g >= 0) && (t == g + 3);
    expBusy  = (g >= 0) && (t > g) && (t <= g + 3);
    checkOutput("busy",    32'(busy),    32'(expBusy));
    checkOutput("m_en",    32'(m_en),    32'(expIssue));
    checkOutput("m_we",    32'(m_we),    32'(expIssue && gwe));
    checkOutput("m_addr",  32'(m_addr),  32'(expAddr));
    checkOutput("m_wdata", 32'(m_wdata), 32'(expWdata));
    checkOutput("c_ack",   32'(c_ack),   32'(expDone && !gw));
    checkOutput("d_ack",   32'(d_ack),   32'(expDone && gw));
    checkOutput("owner",   32'(owner),   32'(ownerExp));
    if (expDone) begin
      checkOutput("rdata", 32'(rdata), 32'(rdExp));
    end
  endtask

  // Model of the rising edge that ends cycle t, using the inputs now driven.
  task automatic modelEdge();
    logic win;
    if ((g < 0 || t >= g + 4) && (cReq || dReq)) begin
      win      = (cReq && dReq) ? ~ownerExp : dReq;
      ownerExp = win;
      g        = t;
      gw       = win;
      gwe      = win ? dWe : cWe;
      expAddr  = win ? dAddr : cAddr;
      expWdata = win ? dWdata : cWdata;
      if (gwe) begin
        refMem[expAddr] = expWdata;
      end else begin
        rdExp = refMem[expAddr];
      end
    end
  endtask

  task automatic step();
    modelEdge();
    @(negedge clk);
    t++;
    compareAll();
  endtask

  task automatic applyStimulus(input logic cr, input logic cw, input logic [AW-1:0] ca,
                               input logic [DW-1:0] cd, input logic dr, input logic dw,
                               input logic [AW-1:0] da, input logic [DW-1:0] dd);
    cReq = cr; cWe = cw; cAddr = ca; cWdata = cd;
    dReq = dr; dWe = dw; dAddr = da; dWdata = dd;
    step();
  endtask

  // Asserts reset mid-cycle, checks the outputs clear at once, and releases
  // on a falling edge so the next rising edge is the first IDLE evaluation.
  task automatic resetDut(input bit keepInputs, input bit preload);
    #2;
    i_rst_n = 1'b0;
    if (!keepInputs) begin
      cReq = 0; cWe = 0; cAddr = '0; cWdata = '0;
      dReq = 0; dWe = 0; dAddr = '0; dWdata = '0;
    end
    #1;
    checkOutput("rst_c_ack",   32'(c_ack),   32'd0);
    checkOutput("rst_d_ack",   32'(d_ack),   32'd0);
    checkOutput("rst_rdata",   32'(rdata),   32'd0);
    checkOutput("rst_m_en",    32'(m_en),    32'd0);
    checkOutput("rst_m_we",    32'(m_we),    32'd0);
    checkOutput("rst_m_addr",  32'(m_addr),  32'd0);
    checkOutput("rst_m_wdata", 32'(m_wdata), 32'd0);
    checkOutput("rst_busy",    32'(busy),    32'd0);
    if (preload) begin
      for (int a = 0; a < DEPTH; a++) begin
        @(negedge clk);
        memLoadEn   = 1'b1;
        memLoadAddr = AW'(a);
        memLoadData = initWord(a);
        refMem[a]   = initWord(a);
      end
    end
    @(negedge clk);
    memLoadEn = 1'b0;
    @(negedge clk);
    checkOutput("rst_hold_c_ack", 32'(c_ack), 32'd0);
    checkOutput("rst_hold_busy",  32'(busy),  32'd0);
    g = -1; gw = 0; gwe = 0;
    expAddr = '0; expWdata = '0; ownerExp = 1'b1; rdExp = '0;
    i_rst_n = 1'b1;
    t = 0;
    compareAll();
  endtask

  // Random requester behaviour: raise with random fields, drop after ack,
  // occasionally change fields while pending or abandon before grant.
  task automatic randomDrive();
    logic ackC, ackD;
    ackC = (g >= 0) && (t == g + 3) && !gw;
    ackD = (g >= 0) && (t == g + 3) && gw;
    if (cReq && ackC) begin
      cReq = 1'b0;
    end else if (!cReq) begin
      if ($urandom_range(2) == 0) begin
        cReq = 1'b1; cWe = 1'($urandom_range(1));
        cAddr = AW'($urandom_range(DEPTH - 1)); cWdata = DW'($urandom_range(255));
      end
    end else begin
      if ($urandom_range(7) == 0) begin
        cAddr = AW'($urandom_range(DEPTH - 1)); cWdata = DW'($urandom_range(255));
        cWe = 1'($urandom_range(1));
      end
      if ($urandom_range(19) == 0) cReq = 1'b0;
    end
    if (dReq && ackD) begin
      dReq = 1'b0;
    end else if (!dReq) begin
      if ($urandom_range(2) == 0) begin
        dReq = 1'b1; dWe = 1'($urandom_range(1));
        dAddr = AW'($urandom_range(DEPTH - 1)); dWdata = DW'($urandom_range(255));
      end
    end else begin
      if ($urandom_range(7) == 0) begin
        dAddr = AW'($urandom_range(DEPTH - 1)); dWdata = DW'($urandom_range(255));
        dWe = 1'($urandom_range(1));
      end
      if ($urandom_range(19) == 0) dReq = 1'b0;
    end
  endtask

  // Main sequence: directed scenarios with literal expectations, then
  // random traffic, then the summary.
  initial begin
    int base;
    nCompared = 0; nMismatched = 0;
    t = 0; g = -1; gw = 0; gwe = 0;
    expAddr = '0; expWdata = '0; ownerExp = 1'b1; rdExp = '0;
    memLoadEn = 1'b0; memLoadAddr = '0; memLoadData = '0;
    i_rst_n = 1'b1;
    cReq = 0; cWe = 0; cAddr = '0; cWdata = '0;
    dReq = 0; dWe = 0; dAddr = '0; dWdata = '0;
    @(negedge clk);
    resetDut(1'b0, 1'b1);
    checkOutput("lit_reset_owner", 32'(owner), 32'd1);

    // CPU read of address 3.
    applyStimulus(1, 0, 5'd3, 8'h00, 0, 0, 5'd0, 8'h00);
    checkOutput("lit_rd_m_en",   32'(m_en),   32'd1);
    checkOutput("lit_rd_m_addr", 32'(m_addr), 32'd3);
    applyStimulus(1, 0, 5'd3, 8'h00, 0, 0, 5'd0, 8'h00);
    applyStimulus(1, 0, 5'd3, 8'h00, 0, 0, 5'd0, 8'h00);
    checkOutput("lit_rd_c_ack", 32'(c_ack), 32'd1);
    checkOutput("lit_rd_rdata", 32'(rdata), 32'h5A);
    checkOutput("lit_rd_d_ack", 32'(d_ack), 32'd0);
    applyStimulus(0, 0, 5'd0, 8'h00, 0, 0, 5'd0, 8'h00);

    // Debug write of 0x21 to address 7, then CPU reads it back.
    base = t;
    applyStimulus(0, 0, 5'd0, 8'h00, 1, 1, 5'd7, 8'h21);
    checkOutput("lit_wr_m_en",    32'(m_en),    32'd1);
    checkOutput("lit_wr_m_we",    32'(m_we),    32'd1);
    checkOutput("lit_wr_m_addr",  32'(m_addr),  32'd7);
    checkOutput("lit_wr_m_wdata", 32'(m_wdata), 32'h21);
    applyStimulus(0, 0, 5'd0, 8'h00, 1, 1, 5'd7, 8'h21);
    applyStimulus(0, 0, 5'd0, 8'h00, 1, 1, 5'd7, 8'h21);
    checkOutput("lit_wr_d_ack_cycle", 32'(t - base), 32'd3);
    checkOutput("lit_wr_d_ack", 32'(d_ack), 32'd1);
    applyStimulus(0, 0, 5'd0, 8'h00, 0, 0, 5'd0, 8'h00);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 5'd7, 8'h00, 0, 0, 5'd0, 8'h00);
    checkOutput("lit_wr_readback", 32'(rdata), 32'h21);
    applyStimulus(0, 0, 5'd0, 8'h00, 0, 0, 5'd0, 8'h00);

    // Address changes after the grant must not reach the RAM.
    applyStimulus(1, 0, 5'd2, 8'h00, 0, 0, 5'd0, 8'h00);
    checkOutput("lit_hold_m_addr", 32'(m_addr), 32'd2);
    applyStimulus(1, 0, 5'd9, 8'h77, 0, 0, 5'd0, 8'h00);
    applyStimulus(1, 0, 5'd9, 8'h77, 0, 0, 5'd0, 8'h00);
    checkOutput("lit_hold_rdata", 32'(rdata), 32'hC3);
    applyStimulus(0, 0, 5'd0, 8'h00, 0, 0, 5'd0, 8'h00);

    // Tie right after reset: CPU first, then alternate.
    resetDut(1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1, 0, 5'd3, 8'h00, 1, 0, 5'd2, 8'h00);
      if (t == 3) begin
        checkOutput("lit_tie_c_ack1", 32'(c_ack), 32'd1);
        checkOutput("lit_tie_owner1", 32'(owner), 32'd0);
      end
      if (t == 7) begin
        checkOutput("lit_tie_d_ack",  32'(d_ack), 32'd1);
        checkOutput("lit_tie_owner2", 32'(owner), 32'd1);
        checkOutput("lit_tie_rdata2", 32'(rdata), 32'hC3);
      end
      if (t == 11) begin
        checkOutput("lit_tie_c_ack2", 32'(c_ack), 32'd1);
        checkOutput("lit_tie_rdata3", 32'(rdata), 32'h5A);
      end
    end
    applyStimulus(0, 0, 5'd0, 8'h00, 0, 0, 5'd0, 8'h00);
    applyStimulus(0, 0, 5'd0, 8'h00, 0, 0, 5'd0, 8'h00);

    // Reset during WAIT aborts the access; it restarts after release.
    resetDut(1'b0, 1'b0);
    applyStimulus(1, 0, 5'd5, 8'h00, 0, 0, 5'd0, 8'h00);
    applyStimulus(1, 0, 5'd5, 8'h00, 0, 0, 5'd0, 8'h00);
    checkOutput("lit_abort_busy", 32'(busy), 32'd1);
    resetDut(1'b1, 1'b0);
    applyStimulus(1, 0, 5'd5, 8'h00, 0, 0, 5'd0, 8'h00);
    applyStimulus(1, 0, 5'd5, 8'h00, 0, 0, 5'd0, 8'h00);
    applyStimulus(1, 0, 5'd5, 8'h00, 0, 0, 5'd0, 8'h00);
    checkOutput("lit_restart_c_ack", 32'(c_ack), 32'd1);
    checkOutput("lit_restart_rdata", 32'(rdata), 32'hC4);
    applyStimulus(0, 0, 5'd0, 8'h00, 0, 0, 5'd0, 8'h00);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      randomDrive();
      step();
    end
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 5'd0, 8'h00, 0, 0, 5'd0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
